// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per clock.
// Optional leading-zero blanking is built when BIN2BCD_BLANK_EN is defined.
module bin2bcd_seq #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned DIGITS = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic [WIDTH-1:0]      bin_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [4*DIGITS-1:0]   bcd_o,
  output logic                  ovf_o,
  output logic [DIGITS-1:0]     blank_o
);

  localparam int unsigned BcdW = 4 * DIGITS;
  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  shift_q, shift_d, shift_sh;
  logic [BcdW-1:0]   dig_q, dig_d, dig_adj, dig_sh;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              sovf_q, sovf_d;
  logic [BcdW-1:0]   bcd_q, bcd_d;
  logic              ovf_q, ovf_d;
  logic              busy_q, done_q;
  logic              top_out;
  logic              load;
  logic              finish;

  // One shared add-3 stage per digit, followed by the 1-bit shift.
  always_comb begin
    dig_adj = dig_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (dig_q[4*i +: 4] >= 4'd5) begin
        dig_adj[4*i +: 4] = dig_q[4*i +: 4] + 4'd3;
      end
    end
    top_out            = dig_adj[BcdW-1];
    {dig_sh, shift_sh} = {dig_adj[BcdW-2:0], shift_q, 1'b0};
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    dig_d   = dig_q;
    cnt_d   = cnt_q;
    sovf_d  = sovf_q;
    bcd_d   = bcd_q;
    ovf_d   = ovf_q;
    load    = 1'b0;
    finish  = 1'b0;
    case (state_q)
      StIdle: begin
        if (start_i) load = 1'b1;
      end
      StShift: begin
        shift_d = shift_sh;
        dig_d   = dig_sh;
        sovf_d  = sovf_q | top_out;
        if (cnt_q == '0) begin
          // Result is registered on the last shift so it is visible during DONE.
          finish  = 1'b1;
          state_d = StDone;
          bcd_d   = dig_sh;
          ovf_d   = sovf_q | top_out;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StDone: begin
        if (start_i) load = 1'b1;
        else         state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (load) begin
      state_d = StShift;
      shift_d = bin_i;
      dig_d   = '0;
      cnt_d   = CntW'(WIDTH - 1);
      sovf_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      shift_q <= '0;
      dig_q   <= '0;
      cnt_q   <= '0;
      sovf_q  <= 1'b0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      dig_q   <= dig_d;
      cnt_q   <= cnt_d;
      sovf_q  <= sovf_d;
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
      busy_q  <= (state_d == StShift);
      done_q  <= (state_d == StDone);
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign bcd_o  = bcd_q;
  assign ovf_o  = ovf_q;

`ifdef BIN2BCD_BLANK_EN
  localparam logic [DIGITS-1:0] BlankRst = {DIGITS{1'b1}} ^ DIGITS'(1);

  logic [DIGITS-1:0] blank_q, blank_d;
  logic              seen;

  // Scan from the top digit down; digit 0 is never blanked.
  always_comb begin
    blank_d = blank_q;
    seen    = 1'b0;
    if (finish) begin
      blank_d = '0;
      for (int i = DIGITS - 1; i >= 1; i--) begin
        seen       = seen | (|dig_sh[4*i +: 4]);
        blank_d[i] = ~seen;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) blank_q <= BlankRst;
    else         blank_q <= blank_d;
  end

  assign blank_o = blank_q;
`else
  assign blank_o = '0;
`endif

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: three parameterisations, vector table,
// corner-case sequences and randomized conversions against an arithmetic model.
module tb_bin2bcd_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start_a, start_b, start_c;
  logic [9:0]  bin_a, bin_b;
  logic [15:0] bin_c;
  logic        busy_a, busy_b, busy_c, done_a, done_b, done_c, ovf_a, ovf_b, ovf_c;
  logic [15:0] bcd_a;
  logic [11:0] bcd_b;
  logic [19:0] bcd_c;
  logic [3:0]  blank_a;
  logic [2:0]  blank_b;
  logic [4:0]  blank_c;

  bin2bcd_seq #(.WIDTH(10), .DIGITS(4)) u_a (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_a), .bin_i(bin_a), .busy_o(busy_a),
    .done_o(done_a), .bcd_o(bcd_a), .ovf_o(ovf_a), .blank_o(blank_a)
  );
  bin2bcd_seq #(.WIDTH(10), .DIGITS(3)) u_b (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_b), .bin_i(bin_b), .busy_o(busy_b),
    .done_o(done_b), .bcd_o(bcd_b), .ovf_o(ovf_b), .blank_o(blank_b)
  );
  bin2bcd_seq u_c (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_c), .bin_i(bin_c), .busy_o(busy_c),
    .done_o(done_c), .bcd_o(bcd_c), .ovf_o(ovf_c), .blank_o(blank_c)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Reference model: plain decimal digit extraction.
  function automatic logic [31:0] ref_bcd(input int unsigned v, input int d);
    logic [31:0]  r;
    int unsigned  x;
    r = '0;
    x = v;
    for (int i = 0; i < d; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [31:0] ref_ovf(input int unsigned v, input int d);
    int unsigned lim;
    lim = 1;
    for (int i = 0; i < d; i++) lim = lim * 10;
    return {31'd0, v >= lim};
  endfunction

  function automatic logic [31:0] exp_blank(input logic [31:0] bcd, input int d);
    logic [31:0] r;
    r = '0;
`ifdef BIN2BCD_BLANK_EN
    for (int i = 1; i < d; i++) r[i] = ((bcd >> (4*i)) == 32'd0);
`endif
    return r;
  endfunction

  function automatic logic [31:0] rst_blank(input int d);
`ifdef BIN2BCD_BLANK_EN
    return ((32'd1 << d) - 32'd1) & ~32'd1;
`else
    return 32'd0;
`endif
  endfunction

  function automatic int width_of(input int sel);
    return (sel == 2) ? 16 : 10;
  endfunction
  function automatic int digits_of(input int sel);
    return (sel == 0) ? 4 : (sel == 1) ? 3 : 5;
  endfunction

  function automatic logic [31:0] cur_bcd(input int sel);
    case (sel)
      0:       return 32'(bcd_a);
      1:       return 32'(bcd_b);
      default: return 32'(bcd_c);
    endcase
  endfunction
  function automatic logic [31:0] cur_blank(input int sel);
    case (sel)
      0:       return 32'(blank_a);
      1:       return 32'(blank_b);
      default: return 32'(blank_c);
    endcase
  endfunction
  function automatic logic cur_done(input int sel);
    return (sel == 0) ? done_a : (sel == 1) ? done_b : done_c;
  endfunction
  function automatic logic cur_busy(input int sel);
    return (sel == 0) ? busy_a : (sel == 1) ? busy_b : busy_c;
  endfunction
  function automatic logic cur_ovf(input int sel);
    return (sel == 0) ? ovf_a : (sel == 1) ? ovf_b : ovf_c;
  endfunction

  task automatic drive(input int sel, input logic s, input int v);
    case (sel)
      0:       begin start_a = s; bin_a = 10'(v); end
      1:       begin start_b = s; bin_b = 10'(v); end
      default: begin start_c = s; bin_c = 16'(v); end
    endcase
  endtask

  // Called at a negedge; the following posedge is cycle 0. Returns at the
  // negedge of the done cycle (or after the cycle budget with lat = -1).
  task automatic conv(input int sel, input int v, output int lat, output int bn);
    drive(sel, 1'b1, v);
    @(negedge clk);
    drive(sel, 1'b0, v);
    lat = -1;
    bn  = 0;
    for (int c = 1; c <= 40; c++) begin
      if (cur_done(sel)) begin
        lat = c;
        break;
      end
      bn += int'(cur_busy(sel));
      @(negedge clk);
    end
  endtask

  task automatic do_check(input int sel, input int v, input logic [31:0] eb, input logic eo);
    int lat, bn;
    conv(sel, v, lat, bn);
    check("latency", 32'(lat), 32'(width_of(sel) + 1));
    check("busy_cycles", 32'(bn), 32'(width_of(sel)));
    check("bcd", cur_bcd(sel), eb);
    check("ovf", {31'd0, cur_ovf(sel)}, {31'd0, eo});
    check("busy_in_done", {31'd0, cur_busy(sel)}, 32'd0);
    check("blank", cur_blank(sel), exp_blank(eb, digits_of(sel)));
  endtask

  typedef struct {
    int          sel;
    int          v;
    logic [31:0] bcd;
    logic        ovf;
  } vec_t;

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t tbl[12];
    logic [31:0] prev, got;
    int dones, done_cyc, bad, v;

    tbl[0]  = '{0, 999,   32'h0999,  1'b0};
    tbl[1]  = '{0, 1023,  32'h1023,  1'b0};
    tbl[2]  = '{0, 0,     32'h0000,  1'b0};
    tbl[3]  = '{0, 512,   32'h0512,  1'b0};
    tbl[4]  = '{0, 1000,  32'h1000,  1'b0};
    tbl[5]  = '{1, 1023,  32'h023,   1'b1};
    tbl[6]  = '{1, 255,   32'h255,   1'b0};
    tbl[7]  = '{1, 1000,  32'h000,   1'b1};
    tbl[8]  = '{1, 999,   32'h999,   1'b0};
    tbl[9]  = '{2, 65535, 32'h65535, 1'b0};
    tbl[10] = '{2, 0,     32'h00000, 1'b0};
    tbl[11] = '{2, 10000, 32'h10000, 1'b0};

    rst_n = 1'b0;
    drive(0, 1'b0, 0);
    drive(1, 1'b0, 0);
    drive(2, 1'b0, 0);
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy_a}, 32'd0);
    check("rst_done", {31'd0, done_a}, 32'd0);
    check("rst_bcd", cur_bcd(0), 32'd0);
    check("rst_ovf", {31'd0, ovf_a}, 32'd0);
    check("rst_blank_a", cur_blank(0), rst_blank(4));
    check("rst_blank_c", cur_blank(2), rst_blank(5));
    rst_n = 1'b1;
    @(negedge clk);

    // Consecutive entries are issued in each other's DONE cycle (back-to-back).
    for (int i = 0; i < 12; i++) do_check(tbl[i].sel, tbl[i].v, tbl[i].bcd, tbl[i].ovf);
    @(negedge clk);
    check("done_single_pulse", {31'd0, done_c}, 32'd0);
    check("idle_after_done", {31'd0, busy_c}, 32'd0);

    // start during SHIFT must be ignored.
    @(negedge clk);
    prev = cur_bcd(0);
    drive(0, 1'b1, 300);
    @(negedge clk);
    drive(0, 1'b0, 300);
    dones = 0;
    done_cyc = -1;
    got = '0;
    for (int c = 1; c <= 20; c++) begin
      if (c == 5) check("bcd_hold_in_shift", cur_bcd(0), prev);
      if (done_a) begin
        dones++;
        if (done_cyc < 0) begin
          done_cyc = c;
          got = cur_bcd(0);
        end
      end
      drive(0, (c == 4), (c == 4) ? 777 : 300);
      @(negedge clk);
    end
    check("ignored_start_dones", 32'(dones), 32'd1);
    check("ignored_start_cycle", 32'(done_cyc), 32'd11);
    check("ignored_start_bcd", got, 32'h0300);

    // Reset in the middle of a conversion aborts it.
    drive(0, 1'b1, 999);
    @(negedge clk);
    drive(0, 1'b0, 999);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy_a}, 32'd0);
    check("abort_done", {31'd0, done_a}, 32'd0);
    check("abort_bcd", cur_bcd(0), 32'd0);
    check("abort_ovf", {31'd0, ovf_a}, 32'd0);
    check("abort_blank", cur_blank(0), rst_blank(4));
    bad = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (c == 3) rst_n = 1'b1;
      bad += int'(done_a) + int'(busy_a);
    end
    check("abort_no_done", 32'(bad), 32'd0);
    do_check(0, 512, 32'h0512, 1'b0);

    // Randomized conversions on the default configuration.
    for (int n = 0; n < 1000; n++) begin
      v = int'($urandom_range(0, 65535));
      do_check(2, v, ref_bcd(v, 5), ref_ovf(v, 5) != 0);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
